// File: rtl/ps2_ascii_src.sv
// PS/2 keyboard receiver: serial frame capture, scancode FIFO and
// set-2 scancode to ASCII decoder driving a one-cycle text-memory write strobe.
module ps2_ascii_src #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TIMEOUT    = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_ascii,
  output logic       key_valid,
  output logic       overflow,
  output logic       frame_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RECV = 1'b1;

  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  // synchronizers
  logic [2:0] clk_sync_q, clk_sync_d;
  logic [2:0] data_sync_q, data_sync_d;
  logic       fall_c;
  logic       data_bit_c;

  // frame receiver
  logic [0:0]    state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    data_sr_q, data_sr_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          push_q, push_d;
  logic [7:0]    push_byte_q, push_byte_d;
  logic          frame_err_q, frame_err_d;

  // scancode FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          overflow_q, overflow_d;
  logic          fifo_empty_c;
  logic          fifo_full_c;
  logic          wr_en_c;
  logic          pop_en;
  logic [7:0]    pop_byte_c;

  // decoder
  logic       brk_q, brk_d;
  logic       ext_q, ext_d;
  logic       shift_q, shift_d;
  logic       caps_q, caps_d;
  logic [7:0] key_ascii_q, key_ascii_d;
  logic       key_valid_q, key_valid_d;
  logic [9:0] map_c;
  logic       is_shift_c;

  assign key_ascii = key_ascii_q;
  assign key_valid = key_valid_q;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

  // Set-2 make code lookup: {valid, is_letter, ascii}; letters returned lowercase.
  function automatic logic [9:0] lookup(input logic [7:0] code, input logic shift);
    logic [9:0] r;
    r = '0;
    case (code)
      8'h1C: r = {2'b11, 8'h61};  // a
      8'h32: r = {2'b11, 8'h62};  // b
      8'h21: r = {2'b11, 8'h63};  // c
      8'h23: r = {2'b11, 8'h64};  // d
      8'h24: r = {2'b11, 8'h65};  // e
      8'h2B: r = {2'b11, 8'h66};  // f
      8'h34: r = {2'b11, 8'h67};  // g
      8'h33: r = {2'b11, 8'h68};  // h
      8'h43: r = {2'b11, 8'h69};  // i
      8'h3B: r = {2'b11, 8'h6A};  // j
      8'h42: r = {2'b11, 8'h6B};  // k
      8'h4B: r = {2'b11, 8'h6C};  // l
      8'h3A: r = {2'b11, 8'h6D};  // m
      8'h31: r = {2'b11, 8'h6E};  // n
      8'h44: r = {2'b11, 8'h6F};  // o
      8'h4D: r = {2'b11, 8'h70};  // p
      8'h15: r = {2'b11, 8'h71};  // q
      8'h2D: r = {2'b11, 8'h72};  // r
      8'h1B: r = {2'b11, 8'h73};  // s
      8'h2C: r = {2'b11, 8'h74};  // t
      8'h3C: r = {2'b11, 8'h75};  // u
      8'h2A: r = {2'b11, 8'h76};  // v
      8'h1D: r = {2'b11, 8'h77};  // w
      8'h22: r = {2'b11, 8'h78};  // x
      8'h35: r = {2'b11, 8'h79};  // y
      8'h1A: r = {2'b11, 8'h7A};  // z
      8'h16: r = {2'b10, shift ? 8'h21 : 8'h31};  // 1 !
      8'h1E: r = {2'b10, shift ? 8'h40 : 8'h32};  // 2 @
      8'h26: r = {2'b10, shift ? 8'h23 : 8'h33};  // 3 #
      8'h25: r = {2'b10, shift ? 8'h24 : 8'h34};  // 4 $
      8'h2E: r = {2'b10, shift ? 8'h25 : 8'h35};  // 5 %
      8'h36: r = {2'b10, shift ? 8'h5E : 8'h36};  // 6 ^
      8'h3D: r = {2'b10, shift ? 8'h26 : 8'h37};  // 7 &
      8'h3E: r = {2'b10, shift ? 8'h2A : 8'h38};  // 8 *
      8'h46: r = {2'b10, shift ? 8'h28 : 8'h39};  // 9 (
      8'h45: r = {2'b10, shift ? 8'h29 : 8'h30};  // 0 )
      8'h29: r = {2'b10, 8'h20};  // space
      8'h5A: r = {2'b10, 8'h0D};  // enter
      8'h66: r = {2'b10, 8'h08};  // backspace
      default: r = '0;
    endcase
    return r;
  endfunction

  // Falling edge seen between the two oldest clock synchronizer stages.
  always_comb begin
    clk_sync_d  = {clk_sync_q[1:0], ps2_clk};
    data_sync_d = {data_sync_q[1:0], ps2_data};
    fall_c      = clk_sync_q[2] & ~clk_sync_q[1];
    data_bit_c  = data_sync_q[1];
  end

  // Frame FSM: start, 8 data bits LSB first, odd parity, stop; inter-edge timeout.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    data_sr_d   = data_sr_q;
    par_d       = par_q;
    to_cnt_d    = to_cnt_q;
    push_d      = 1'b0;
    push_byte_d = push_byte_q;
    frame_err_d = frame_err_q;
    case (state_q)
      ST_IDLE: begin
        to_cnt_d = '0;
        if (fall_c) begin
          if (!data_bit_c) begin
            state_d   = ST_RECV;
            bit_cnt_d = 4'd1;
            par_d     = 1'b0;
            data_sr_d = '0;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      ST_RECV: begin
        if (fall_c) begin
          to_cnt_d = '0;
          if (bit_cnt_q <= 4'd8) begin
            data_sr_d = {data_bit_c, data_sr_q[7:1]};
            par_d     = par_q ^ data_bit_c;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (bit_cnt_q == 4'd9) begin
            par_d     = par_q ^ data_bit_c;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            // par_q holds xor of data and parity bits: 1 means odd parity holds
            if (par_q && data_bit_c) begin
              push_d      = 1'b1;
              push_byte_d = data_sr_q;
            end else begin
              frame_err_d = 1'b1;
            end
          end
        end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
          state_d     = ST_IDLE;
          bit_cnt_d   = '0;
          to_cnt_d    = '0;
          frame_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        bit_cnt_d = '0;
      end
    endcase
  end

  // FIFO status, pop-before-push arbitration and pointer update.
  assign pop_en = ~fifo_empty_c;

  always_comb begin
    fifo_empty_c = (wr_ptr_q == rd_ptr_q);
    fifo_full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    wr_en_c      = push_q && (!fifo_full_c || pop_en);
    rd_ptr_d     = rd_ptr_q + (AW+1)'(pop_en);
    wr_ptr_d     = wr_ptr_q + (AW+1)'(wr_en_c);
    overflow_d   = overflow_q | (push_q & ~wr_en_c);
    pop_byte_c   = mem[rd_ptr_q[AW-1:0]];
  end

  // Scancode decoder: break/extended prefixes, shift and caps tracking, ASCII strobe.
  always_comb begin
    brk_d       = brk_q;
    ext_d       = ext_q;
    shift_d     = shift_q;
    caps_d      = caps_q;
    key_ascii_d = key_ascii_q;
    key_valid_d = 1'b0;
    map_c       = lookup(pop_byte_c, shift_q);
    is_shift_c  = (pop_byte_c == SC_LSHIFT) || (pop_byte_c == SC_RSHIFT);
    if (pop_en) begin
      if (pop_byte_c == SC_BRK) begin
        brk_d = 1'b1;
      end else if (pop_byte_c == SC_EXT) begin
        ext_d = 1'b1;
      end else if (brk_q) begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        if (is_shift_c && !ext_q) begin
          shift_d = 1'b0;
        end
      end else begin
        ext_d = 1'b0;
        if (!ext_q) begin
          if (is_shift_c) begin
            shift_d = 1'b1;
          end else if (pop_byte_c == SC_CAPS) begin
            caps_d = ~caps_q;
          end else if (map_c[9]) begin
            key_valid_d = 1'b1;
            key_ascii_d = (map_c[8] && (shift_q ^ caps_q)) ? (map_c[7:0] - 8'h20)
                                                           : map_c[7:0];
          end
        end
      end
    end
  end

  // FIFO storage; contents need no reset since pointers define occupancy.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wr_ptr_q[AW-1:0]] <= push_byte_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q  <= '0;
      data_sync_q <= '0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      data_sr_q   <= '0;
      par_q       <= 1'b0;
      to_cnt_q    <= '0;
      push_q      <= 1'b0;
      push_byte_q <= '0;
      frame_err_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      shift_q     <= 1'b0;
      caps_q      <= 1'b0;
      key_ascii_q <= '0;
      key_valid_q <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      data_sr_q   <= data_sr_d;
      par_q       <= par_d;
      to_cnt_q    <= to_cnt_d;
      push_q      <= push_d;
      push_byte_q <= push_byte_d;
      frame_err_q <= frame_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      brk_q       <= brk_d;
      ext_q       <= ext_d;
      shift_q     <= shift_d;
      caps_q      <= caps_d;
      key_ascii_q <= key_ascii_d;
      key_valid_q <= key_valid_d;
    end
  end

endmodule

// File: tb/tb_ps2_ascii_src.sv
// Directed bench for ps2_ascii_src: serial PS/2 frames in, ASCII strobes out.
module tb_ps2_ascii_src;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TO    = 1000;
  localparam int unsigned H     = 8;   // PS/2 half bit period in clk cycles

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] key_ascii;
  logic       key_valid;
  logic       overflow;
  logic       frame_err;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int stop_cyc = 0;

  logic [7:0] got_q[$];
  int         got_cyc[$];
  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];

  ps2_ascii_src #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .key_ascii (key_ascii),
    .key_valid (key_valid),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // capture every strobe once, away from the active edge
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      got_q.push_back(key_ascii);
      got_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic ps2_bit(input logic v, input bit last);
    ps2_data = v;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    if (last) stop_cyc = cyc;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ flip_par, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i <= 10; i++) ps2_bit(bits[i], i == 10);
    ps2_data = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_list();
    for (int i = 0; i < tx_q.size(); i++) send_frame(tx_q[i], 1'b0);
    repeat (12) @(negedge clk);
  endtask

  task automatic check_out(input string tag);
    logic [31:0] g;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? {24'h0, got_q[i]} : 32'hFFFF_FFFF;
      chk($sformatf("%s_%0d", tag, i), g, {24'h0, exp_q[i]});
    end
    got_q.delete();
    got_cyc.delete();
  endtask

  initial begin
    reset = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    do_reset();

    // reset state
    chk("rst_valid", key_valid, 0);
    chk("rst_ascii", key_ascii, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_state", dut.state_q, 0);

    // single 'a'; edge reaches compare stages 2 clk after the line falls, then 3 clk
    send_frame(8'h1C, 1'b0);
    repeat (12) @(negedge clk);
    chk("lat", (got_cyc.size() > 0) ? got_cyc[0] - stop_cyc : -1, 5);
    exp_q = '{8'h61};
    check_out("a");

    // shift make/break, break codes silent
    tx_q = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h1C};
    send_list();
    exp_q = '{8'h41, 8'h61};
    check_out("shift");

    // caps xor shift, enter
    tx_q = '{8'h58, 8'h1C, 8'h12, 8'h1C, 8'h5A};
    send_list();
    exp_q = '{8'h41, 8'h61, 8'h0D};
    check_out("caps");

    // release shift, caps off; digits, symbols, space, bksp, ext/unmapped, typematic
    tx_q = '{8'hF0, 8'h12, 8'h58, 8'h12, 8'h16, 8'hF0, 8'h12, 8'h16, 8'h45,
             8'h29, 8'h66, 8'hE0, 8'h1C, 8'hE0, 8'hF0, 8'h1C, 8'h05, 8'h1C, 8'h1C};
    send_list();
    exp_q = '{8'h21, 8'h31, 8'h30, 8'h20, 8'h08, 8'h61, 8'h61};
    check_out("mix");

    // bad parity
    chk("ferr_pre", frame_err, 0);
    send_frame(8'h1C, 1'b1);
    repeat (12) @(negedge clk);
    chk("ferr_par", frame_err, 1);
    exp_q = '{};
    check_out("par_drop");
    tx_q = '{8'h32};
    send_list();
    exp_q = '{8'h62};
    check_out("after_par");

    // reset clears sticky flag
    do_reset();
    chk("rst_ferr2", frame_err, 0);

    // timeout after 3 bits
    @(negedge clk);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_data = 1'b1;
    repeat (TO + 20) @(negedge clk);
    chk("to_ferr", frame_err, 1);
    chk("to_state", dut.state_q, 0);
    tx_q = '{8'h1C};
    send_list();
    exp_q = '{8'h61};
    check_out("after_to");

    // idle edge with data high is not a start bit
    do_reset();
    @(negedge clk);
    ps2_bit(1'b1, 1'b0);
    repeat (8) @(negedge clk);
    chk("idle_ferr", frame_err, 1);
    chk("idle_state", dut.state_q, 0);

    // reset mid-frame discards partial frame
    do_reset();
    @(negedge clk);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    do_reset();
    tx_q = '{8'h2B};
    send_list();
    chk("mid_ferr", frame_err, 0);
    exp_q = '{8'h66};
    check_out("mid_rst");

    // overflow with decoder stalled
    do_reset();
    force dut.pop_en = 1'b0;
    tx_q = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33};
    send_list();
    chk("ovf_pre", overflow, 0);
    tx_q = '{8'h43};
    send_list();
    chk("ovf_set", overflow, 1);
    chk("ovf_ferr", frame_err, 0);
    exp_q = '{};
    check_out("ovf_stalled");
    release dut.pop_en;
    repeat (20) @(negedge clk);
    exp_q = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68};
    check_out("ovf_drain");
    chk("ovf_sticky", overflow, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ps2_ascii_src.md
PS2_ASCII_SRC -- requirements
Module: ps2_ascii_src

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 8, meaning the scancode FIFO depth in entries (power of two, 4..64).
REQ-002 The block SHALL have parameter TIMEOUT, default 20000, meaning the clk cycles allowed between PS/2 clock falling edges inside a frame before abort.
REQ-003 The block SHALL have port clk, input, 1, system clock.
REQ-004 The block SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 The block SHALL have port ps2_clk, input, 1, asynchronous PS/2 device clock.
REQ-006 The block SHALL have port ps2_data, input, 1, asynchronous PS/2 device data.
REQ-007 The block SHALL have port key_ascii, output, 8, ASCII code of the decoded key press.
REQ-008 The block SHALL have port key_valid, output, 1, one-cycle strobe qualifying key_ascii; this is the text-memory write port.
REQ-009 The block SHALL have port overflow, output, 1, sticky flag: a scancode was dropped because the FIFO was full.
REQ-010 The block SHALL have port frame_err, output, 1, sticky flag: a frame failed the parity, start or stop check, or timed out.

Function
REQ-011 The block SHALL pass ps2_clk and ps2_data through 3-flop synchronizers and detect ps2_clk falling edges on the two oldest stages.
REQ-012 The frame FSM SHALL have two states, IDLE and RECV, and a 4-bit bit counter.
REQ-013 In IDLE, a falling edge with ps2_data sampled 0 SHALL enter RECV with counter=1.
REQ-014 In IDLE, a falling edge with ps2_data sampled 1 SHALL be ignored and SHALL set frame_err.
REQ-015 In RECV, each falling edge SHALL sample one bit: bits 1-8 are data LSB first, bit 9 is odd parity, bit 10 is stop (=1).
REQ-016 On bit 10, the FSM SHALL return to IDLE.
REQ-017 On bit 10, if the parity is odd and stop=1, the FSM SHALL push the data byte into the FIFO on the next clk; otherwise it SHALL drop the byte and set frame_err.
REQ-018 In RECV, a timeout counter SHALL reset on each edge; reaching TIMEOUT SHALL drop the frame, return to IDLE and set frame_err.
REQ-019 The FIFO SHALL use read/write pointers one bit wider than log2(FIFO_DEPTH); full and empty SHALL be derived from the MSB and remaining pointer bits; pointers SHALL wrap naturally.
REQ-020 A push while full SHALL drop the new byte, leave the FIFO contents unchanged and set overflow.
REQ-021 A simultaneous push and pop on a full FIFO SHALL succeed (pop first).
REQ-022 The decoder SHALL pop one entry per cycle whenever the FIFO is not empty, with state flags brk (F0 seen), ext (E0 seen), shift and caps.
REQ-023 Popped 0xF0 SHALL set brk; popped 0xE0 SHALL set ext; neither SHALL produce output.
REQ-024 Any other popped code with brk=1 SHALL clear brk and ext.
REQ-025 If that code is 0x12 or 0x59 and ext=0, shift SHALL clear; there SHALL be no output.
REQ-026 A make of 0x12/0x59 (ext=0) SHALL set shift; a make of 0x58 SHALL toggle caps; ext is cleared after any non-prefix code; neither SHALL produce output.
REQ-027 Any other make with ext=0 SHALL be translated via the table: 0x1C..0x1A letters a-z (uppercase iff shift XOR caps), 0x16..0x45 digits 1-0 (US shifted symbols when shift), 0x29->0x20, 0x5A->0x0D, 0x66->0x08.
REQ-028 Extended makes and unmapped codes SHALL produce no output.
REQ-029 Repeated makes (typematic) SHALL each produce output.
REQ-030 key_valid SHALL assert for exactly one cycle, registered, the cycle after the pop of a mappable make.
REQ-031 key_ascii SHALL hold its last value until the next strobe.
REQ-032 End-to-end latency, with the FIFO empty, SHALL be 3 clk from detection of the stop-bit edge at the synchronizer output to key_valid=1.

Reset
REQ-033 While reset=1, all of the following SHALL be 0 on the next clk and held: FSM=IDLE, counters, FIFO pointers, brk, ext, shift, caps, key_ascii, key_valid, overflow, frame_err.
REQ-034 Reset asserted mid-frame SHALL discard the partial frame; the first falling edge after release SHALL be treated as a start bit per REQ-013/REQ-014.

Verification
REQ-035 Send frame 0x1C (correct parity) -> key_valid single pulse, key_ascii=0x61, 3 clk after stop edge.
REQ-036 Send 0x12, 0x1C, F0 1C, F0 12, 0x1C -> outputs 0x41 then 0x61 only; break codes produce no strobe.
REQ-037 Send 0x58, 0x1C, 0x12, 0x1C -> outputs 0x41 then 0x61 (caps XOR shift); 0x5A -> 0x0D.
REQ-038 Send 0x1C with a flipped parity bit -> no strobe, frame_err=1; the next good 0x32 -> 0x62.
REQ-039 Send 3 bits then stall ps2_clk for TIMEOUT+1 cycles -> frame_err=1, FSM IDLE; the following full frame decodes correctly.
REQ-040 Hold decoder-side pop disabled (bench force) and push FIFO_DEPTH+1 frames -> overflow=1, first 8 bytes retained in order.
